// File: rtl/lts_averager.sv
// LTS averager: buffers the first long training symbol of a burst, then
// averages it sample-by-sample with the second symbol. The averaged symbol
// is emitted on an AXI-Stream style output with a single output register.
module lts_averager #(
  parameter int N_SYM  = 64,
  parameter int DATA_W = 16
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                lts_axis_tvalid,
  input  logic                lts_axis_tlast,
  input  logic [2*DATA_W-1:0] lts_axis_tdata,
  output logic                lts_axis_tready,
  output logic                avg_axis_tvalid,
  output logic                avg_axis_tlast,
  output logic [2*DATA_W-1:0] avg_axis_tdata,
  input  logic                avg_axis_tready,
  output logic                frame_done_out,
  output logic                frame_err_out
);

  localparam int IDX_W = $clog2(N_SYM);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SYM - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_AVERAGE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                up_q;
  logic                avg_valid_q, avg_valid_d;
  logic                avg_last_q, avg_last_d;
  logic [2*DATA_W-1:0] avg_data_q, avg_data_d;
  logic                err_q, err_d;
  logic                done_s;
  logic                ready_s;
  logic                in_fire_s;
  logic                out_fire_s;
  logic [2*DATA_W-1:0] buf_rd_s;
  logic [2*DATA_W-1:0] avg_res_s;
  logic [2*DATA_W-1:0] buffer_q [N_SYM];

  // Floor-average of two signed components; the DATA_W+1 bit sum keeps the
  // carry so the halved result always fits back into DATA_W bits.
  function automatic logic [DATA_W-1:0] avg_comp(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    return DATA_W'($signed(sum) >>> 1);
  endfunction

  assign in_fire_s  = lts_axis_tvalid && ready_s;
  assign out_fire_s = avg_valid_q && avg_axis_tready;
  assign buf_rd_s   = buffer_q[idx_q];
  assign avg_res_s  = {avg_comp(buf_rd_s[2*DATA_W-1:DATA_W], lts_axis_tdata[2*DATA_W-1:DATA_W]),
                       avg_comp(buf_rd_s[DATA_W-1:0],        lts_axis_tdata[DATA_W-1:0])};

  assign lts_axis_tready = ready_s;
  assign avg_axis_tvalid = avg_valid_q;
  assign avg_axis_tlast  = avg_last_q;
  assign avg_axis_tdata  = avg_data_q;
  assign frame_done_out  = done_s;
  assign frame_err_out   = err_q;

  // Input ready: open in FILL, follows the output register in AVERAGE, closed in DRAIN.
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      ST_FILL:    ready_s = up_q;
      ST_AVERAGE: ready_s = up_q && (avg_axis_tready || !avg_valid_q);
      ST_DRAIN:   ready_s = 1'b0;
      default:    ready_s = 1'b0;
    endcase
  end

  // Next-state, sample index, output register and status pulse decisions.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    avg_valid_d = avg_valid_q;
    avg_last_d  = avg_last_q;
    avg_data_d  = avg_data_q;
    err_d       = 1'b0;
    done_s      = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (in_fire_s) begin
          if (lts_axis_tlast) begin
            // Burst too short: drop it and restart collection.
            err_d = 1'b1;
            idx_d = IDX_ZERO;
          end else if (idx_q == IDX_LAST) begin
            idx_d   = IDX_ZERO;
            state_d = ST_AVERAGE;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_AVERAGE: begin
        if (out_fire_s) begin
          avg_valid_d = 1'b0;
          avg_last_d  = 1'b0;
        end else begin
          avg_valid_d = avg_valid_q;
        end
        if (in_fire_s) begin
          if (lts_axis_tlast && (idx_q != IDX_LAST)) begin
            // Second symbol cut short: truncate the output and report it.
            err_d       = 1'b1;
            avg_valid_d = 1'b0;
            avg_last_d  = 1'b0;
            idx_d       = IDX_ZERO;
            state_d     = ST_FILL;
          end else begin
            avg_data_d  = avg_res_s;
            avg_valid_d = 1'b1;
            avg_last_d  = (idx_q == IDX_LAST);
            if (idx_q == IDX_LAST) begin
              // Frame is length-defined; input tlast is not required here.
              idx_d   = IDX_ZERO;
              state_d = ST_DRAIN;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_DRAIN: begin
        if (out_fire_s) begin
          avg_valid_d = 1'b0;
          avg_last_d  = 1'b0;
          done_s      = avg_last_q;
          idx_d       = IDX_ZERO;
          state_d     = ST_FILL;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d     = ST_FILL;
        idx_d       = IDX_ZERO;
        avg_valid_d = 1'b0;
        avg_last_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_FILL;
      idx_q       <= IDX_ZERO;
      up_q        <= 1'b0;
      avg_valid_q <= 1'b0;
      avg_last_q  <= 1'b0;
      avg_data_q  <= {(2*DATA_W){1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      up_q        <= 1'b1;
      avg_valid_q <= avg_valid_d;
      avg_last_q  <= avg_last_d;
      avg_data_q  <= avg_data_d;
      err_q       <= err_d;
    end
  end

  // First-symbol storage; contents are always rewritten before being read.
  always_ff @(posedge clk_in) begin
    if ((state_q == ST_FILL) && in_fire_s) begin
      buffer_q[idx_q] <= lts_axis_tdata;
    end
  end

endmodule

// File: tb/tb_lts_averager.sv
// Directed self-checking bench for lts_averager (N_SYM=64, DATA_W=16).
module tb_lts_averager;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_last, out_ready;
  logic [31:0] out_data;
  logic        done, err;

  int vectors = 0;
  int miscompares = 0;

  logic [32:0] out_q[$];
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int stab_viol = 0;
  bit prev_stall = 1'b0;
  logic [32:0] prev_beat;
  bit bp_mode = 1'b0;

  logic signed [15:0] a_i [N];
  logic signed [15:0] a_q [N];
  logic signed [15:0] b_i [N];
  logic signed [15:0] b_q [N];

  lts_averager #(.N_SYM(64), .DATA_W(16)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .lts_axis_tvalid (in_valid),
    .lts_axis_tlast  (in_last),
    .lts_axis_tdata  (in_data),
    .lts_axis_tready (in_ready),
    .avg_axis_tvalid (out_valid),
    .avg_axis_tlast  (out_last),
    .avg_axis_tdata  (out_data),
    .avg_axis_tready (out_ready),
    .frame_done_out  (done),
    .frame_err_out   (err)
  );

  always #5 clk = ~clk;

  // Downstream ready: always 1, or random 30% duty when backpressure is on.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) out_ready = ($urandom_range(0, 99) < 30);
      else         out_ready = 1'b1;
    end
  end

  // Output monitor, sampled mid-cycle: records handshakes, pulses, stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid && ({out_last, out_data} !== prev_beat)) stab_viol++;
      if (out_valid && out_ready) out_q.push_back({out_last, out_data});
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_last, out_data};
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done && err) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference floor((a+b)/2): subtract the odd bit so the division is exact.
  function automatic logic [15:0] avg_model(input logic signed [15:0] a, input logic signed [15:0] b);
    int s;
    s = int'(a) + int'(b);
    return 16'((s - (s & 1)) / 2);
  endfunction

  task automatic cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] iv, input logic [15:0] qv, input logic last, input bit gaps);
    bit acc;
    int n;
    if (gaps && ($urandom_range(0, 3) == 0)) begin
      in_valid = 1'b0;
      cycles(1);
    end
    in_valid = 1'b1;
    in_data  = {qv, iv};
    in_last  = last;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) check("send_accept", {63'd0, acc}, 64'd1);
  endtask

  task automatic set_const(input int ai, input int aq, input int bi, input int bq);
    for (int k = 0; k < N; k++) begin
      a_i[k] = 16'(ai); a_q[k] = 16'(aq); b_i[k] = 16'(bi); b_q[k] = 16'(bq);
    end
  endtask

  task automatic run_burst(input bit gaps);
    int d0;
    int n;
    logic [31:0] exp;
    out_q.delete();
    d0 = done_cnt;
    for (int k = 0; k < 2 * N; k++) begin
      if (k < N) send(a_i[k], a_q[k], 1'b0, gaps);
      else       send(b_i[k-N], b_q[k-N], (k == 2 * N - 1), gaps);
      if (k == N - 1) check("no_out_before_b", {63'd0, out_valid}, 64'd0);
      if (k == N) begin
        check("first_out_valid", {63'd0, out_valid}, 64'd1);
        check("first_out_data", {32'd0, out_data},
              {32'd0, avg_model(a_q[0], b_q[0]), avg_model(a_i[0], b_i[0])});
      end
    end
    n = 0;
    while (done_cnt < d0 + 1 && n < 1000) begin
      cycles(1);
      n++;
    end
    cycles(3);
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("out_count", 64'(out_q.size()), 64'(N));
    for (int k = 0; k < N && k < out_q.size(); k++) begin
      exp = {avg_model(a_q[k], b_q[k]), avg_model(a_i[k], b_i[k])};
      check($sformatf("data[%0d]", k), {32'd0, out_q[k][31:0]}, {32'd0, exp});
      check($sformatf("last[%0d]", k), {63'd0, out_q[k][32]}, {63'd0, (k == N - 1)});
    end
  endtask

  initial begin
    int e0;
    bit any_last;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 32'd0;
    #2;
    check("rst_tready", {63'd0, in_ready}, 64'd0);
    check("rst_outs", {29'd0, out_valid, out_last, done, err, out_data}, 64'd0);
    #20;
    rst_n = 1'b1;
    #1;
    check("tready_before_edge", {63'd0, in_ready}, 64'd0);
    cycles(1);
    check("tready_after_edge", {63'd0, in_ready}, 64'd1);

    // Nominal: A=(100,-200), B=(300,-400) -> (200,-300)
    set_const(100, -200, 300, -400);
    run_burst(1'b0);
    check("nominal_hand", {32'd0, out_q[0][31:0]}, {32'd0, 16'hFED4, 16'd200});

    // Extremes and rounding toward -infinity.
    set_const(32767, -32768, 32766, -32767);
    run_burst(1'b0);
    check("extreme_hand", {32'd0, out_q[5][31:0]}, {32'd0, 16'h8000, 16'd32766});
    set_const(1, -1, 0, 0);
    run_burst(1'b0);
    check("round_hand", {32'd0, out_q[0][31:0]}, {32'd0, 16'hFFFF, 16'd0});

    // Varied samples under backpressure and input gaps.
    for (int k = 0; k < N; k++) begin
      a_i[k] = 16'(k * 97 - 3000);
      a_q[k] = 16'(1234 - k * 53);
      b_i[k] = 16'(1000 - k * 31);
      b_q[k] = 16'(k * 7 - 11);
    end
    bp_mode = 1'b1;
    run_burst(1'b1);
    check("stable_while_stalled", 64'(stab_viol), 64'd0);
    set_const(100, -200, 300, -400);
    run_burst(1'b1);
    bp_mode = 1'b0;
    cycles(2);

    // Early tlast in FILL at beat 10, then a clean burst.
    out_q.delete();
    e0 = err_cnt;
    for (int k = 0; k <= 10; k++) send(16'd5, 16'd6, (k == 10), 1'b0);
    cycles(5);
    check("fill_abort_err", 64'(err_cnt - e0), 64'd1);
    check("fill_abort_noout", 64'(out_q.size()), 64'd0);
    set_const(-7, 9, 4, -2);
    run_burst(1'b0);

    // Early tlast in AVERAGE at beat 100, then a clean burst.
    out_q.delete();
    e0 = err_cnt;
    for (int k = 0; k <= 100; k++) send(16'd10, 16'd20, (k == 100), 1'b0);
    cycles(5);
    check("avg_abort_err", 64'(err_cnt - e0), 64'd1);
    check("avg_abort_count_le36", {63'd0, (out_q.size() <= 36)}, 64'd1);
    any_last = 1'b0;
    foreach (out_q[k]) if (out_q[k][32]) any_last = 1'b1;
    check("avg_abort_nolast", {63'd0, any_last}, 64'd0);
    check("avg_abort_valid_low", {63'd0, out_valid}, 64'd0);
    set_const(100, -200, 300, -400);
    run_burst(1'b0);

    // Asynchronous reset mid-AVERAGE, between clock edges.
    for (int k = 0; k < 80; k++) send(16'd50, 16'd60, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outs", {28'd0, in_ready, out_valid, out_last, done, err, out_data}, 64'd0);
    cycles(2);
    #2;
    rst_n = 1'b1;
    cycles(2);
    set_const(-300, 400, 301, -399);
    run_burst(1'b0);

    check("err_done_exclusive", 64'(both_cnt), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lts_averager.md
Name: lts_averager

Overview:
- Sits directly downstream of the LTS extractor and upstream of the channel-estimation FFT.
- Accepts one LTS burst of 2*N_SYM complex samples per frame (the two long training symbols back-to-back, tlast on the final sample).
- Buffers the first symbol, then averages it sample-by-sample with the second symbol.
- Emits one N_SYM-sample averaged symbol (tlast on its final sample), improving SNR before FFT.

Parameters:
- N_SYM, 64, samples per LTS symbol (power of two, 16..256).
- DATA_W, 16, bits per I and per Q component.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset: asynchronous assert, active-low; all state cleared while low.
- lts_axis_tvalid  input  1  input sample valid.
- lts_axis_tlast  input  1  marks final sample of the LTS burst.
- lts_axis_tdata  input  2*DATA_W  {Q, I}, I in LSBs, two's complement.
- lts_axis_tready  output  1  input ready.
- avg_axis_tvalid  output  1  averaged sample valid.
- avg_axis_tlast  output  1  marks sample N_SYM-1 of the averaged symbol.
- avg_axis_tdata  output  2*DATA_W  {Q, I} averaged sample.
- avg_axis_tready  input  1  downstream ready.
- frame_done_out  output  1  one-cycle pulse when the averaged tlast beat is accepted downstream.
- frame_err_out  output  1  one-cycle pulse when a burst is aborted by an early tlast.

Behaviour:
- Reset values: lts_axis_tready=0, avg_axis_tvalid=0, avg_axis_tlast=0, avg_axis_tdata=0, frame_done_out=0, frame_err_out=0. Both counters=0, state=FILL.
- tready rises on the first clock edge after rst_n_in deasserts.
- Storage: N_SYM x 2*DATA_W buffer (inferred RAM or register array), written in FILL, read in AVERAGE. Sample index counter idx is log2(N_SYM) bits.
- State FILL:
  - lts_axis_tready=1.
  - Each accepted beat (tvalid&&tready) writes buffer[idx] and increments idx.
  - On acceptance with idx==N_SYM-1: idx wraps to 0 and the state goes to AVERAGE.
  - Accepted beat with tlast=1 (any idx in FILL): abort; pulse frame_err_out next cycle; idx<=0; stay in FILL; no output produced.
- State AVERAGE:
  - lts_axis_tready = avg_axis_tready || !avg_axis_tvalid (single output register; no extra skid).
  - Each accepted beat computes, per component, sum = sext(buffer[idx]) + sext(in), DATA_W+1 bits. Result = sum >>> 1, arithmetic shift, truncating toward -infinity. Result is always representable, so no saturation is needed.
  - Result is registered to avg_axis_tdata with avg_axis_tvalid=1 on the next edge (latency 1 cycle from input acceptance).
  - avg_axis_tlast=1 when idx==N_SYM-1.
  - Output holds tdata/tlast/tvalid stable until avg_axis_tready; tvalid drops the cycle after acceptance if no new beat arrived.
  - Accepted beat with idx==N_SYM-1: the state goes to DRAIN, regardless of input tlast. A missing input tlast is not an error: the frame is length-defined.
  - Accepted beat with tlast=1 and idx<N_SYM-1: abort. Pulse frame_err_out, clear avg_axis_tvalid (the partially emitted symbol is truncated; downstream relies on frame_err_out), idx<=0, go to FILL.
- State DRAIN:
  - lts_axis_tready=0.
  - When the output beat with tlast is accepted: pulse frame_done_out in the same cycle as the handshake, idx<=0, go to FILL.
- Simultaneous events:
  - Output acceptance and new input acceptance in the same AVERAGE cycle: the output register loads the new result, with no bubble.
  - frame_err_out and frame_done_out are never both asserted.
- Reset mid-frame: everything returns to reset values asynchronously. Buffer contents need not clear; they are overwritten before use.
- Throughput: one sample/clock sustained when avg_axis_tready=1. One dead cycle in DRAIN per frame is acceptable.

Test Plan:
- Nominal, N_SYM=64, tready=1: send symbol A with all samples I=100, Q=-200, then symbol B with I=300, Q=-400, tlast on beat 127 -> 64 outputs I=200, Q=-300. First output appears 1 cycle after beat 64 is accepted; tlast on output 63; frame_done_out pulses once.
- Rounding/extremes: A=I 32767, Q -32768; B=I 32766, Q -32767 -> I=32766, Q=-32768. Also A=1, B=0 -> 0; A=-1, B=0 -> -1.
- Backpressure: randomise avg_axis_tready at 30% duty and tvalid gaps -> outputs bit-identical to the nominal run. No beat is lost or duplicated; tdata is stable while tvalid&&!tready.
- Early tlast in FILL at beat 10, then a full clean burst -> frame_err_out one pulse, no output for the aborted burst, the clean burst averages correctly.
- Early tlast in AVERAGE at beat 100 -> frame_err_out pulse, at most 36 outputs seen with no output tlast, then the next clean burst is correct.
- Async reset: deassert rst_n_in mid-AVERAGE, between clock edges -> all outputs go to 0 immediately; after release, a fresh burst processes correctly from idx 0.
